// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS fetch unit.
//   fetch_state_e : fetch sequencer states
//   INSTR_NOP     : instruction value presented while nothing has been fetched
//   PC_INC        : byte distance between sequential instructions
package mips_pkg;

    typedef enum logic [1:0] {
        FETCH_IDLE = 2'd0,
        FETCH      = 2'd1,
        HOLD       = 2'd2
    } fetch_state_e;

    localparam logic [31:0] INSTR_NOP = 32'h0000_0000;
    localparam logic [31:0] PC_INC    = 32'd4;

endpackage

// File: rtl/mips_next_pc.sv
// Next-PC computation for a retiring instruction (pure combinational).
//   i_instr_pc      : address of the retiring instruction
//   i_branch_taken  : conditional branch resolved taken
//   i_branch_offset : sign-extended word offset relative to instr_pc + 4
//   i_jump          : unconditional jump, overrides the branch
//   i_jump_index    : 26-bit word index within the current 256 MB region
//   o_next_pc       : address of the next instruction to fetch
module mips_next_pc (
    input  logic [31:0] i_instr_pc,
    input  logic        i_branch_taken,
    input  logic [31:0] i_branch_offset,
    input  logic        i_jump,
    input  logic [25:0] i_jump_index,
    output logic [31:0] o_next_pc
);
    import mips_pkg::*;

    logic [31:0] w_pc4;
    logic [31:0] w_offset_bytes;
    logic [31:0] w_branch_target;
    logic [31:0] w_jump_target;

    assign w_pc4           = i_instr_pc + PC_INC;
    // Offset bits shifted out the top are discarded: the target wraps mod 2^32.
    assign w_offset_bytes  = i_branch_offset << 2;
    assign w_branch_target = w_pc4 + w_offset_bytes;
    assign w_jump_target   = {w_pc4[31:28], i_jump_index, 2'b00};

    always_comb begin
        o_next_pc = w_pc4;
        if (i_jump) begin
            o_next_pc = w_jump_target;
        end else if (i_branch_taken) begin
            o_next_pc = w_branch_target;
        end
    end

endmodule

// File: rtl/mips_fetch_unit.sv
// Instruction fetch unit: owns the PC, fetches one word at a time over a
// req/ready handshake, holds it for decode until acknowledged, then advances.
//   i_clk, i_reset        : clock, asynchronous active-high reset
//   o_imem_req/o_imem_addr: fetch request and word-aligned address
//   i_imem_ready/rdata    : memory response, data valid with ready
//   o_instr/o_instr_pc    : held instruction and its address
//   o_instr_valid         : held instruction is valid
//   i_instr_ack           : consumer retires the held instruction
//   i_branch_taken/offset : branch outcome, sampled only at retire
//   i_jump/i_jump_index   : jump outcome, sampled only at retire
//   o_instr_count         : retired-instruction counter
module mips_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        i_clk,
    input  logic        i_reset,
    output logic        o_imem_req,
    output logic [31:0] o_imem_addr,
    input  logic        i_imem_ready,
    input  logic [31:0] i_imem_rdata,
    output logic [31:0] o_instr,
    output logic [31:0] o_instr_pc,
    output logic        o_instr_valid,
    input  logic        i_instr_ack,
    input  logic        i_branch_taken,
    input  logic [31:0] i_branch_offset,
    input  logic        i_jump,
    input  logic [25:0] i_jump_index,
    output logic [31:0] o_instr_count
);
    import mips_pkg::*;

    localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

    fetch_state_e r_state;
    fetch_state_e w_state_next;

    logic [31:0] r_pc;
    logic [31:0] r_instr;
    logic [31:0] r_instr_pc;
    logic        r_instr_valid;
    logic [31:0] r_instr_count;

    logic        w_fetch_done;
    logic        w_retire;
    logic [31:0] w_next_pc;

    assign w_fetch_done = (r_state == FETCH) && i_imem_ready;
    assign w_retire     = (r_state == HOLD) && i_instr_ack;

    mips_next_pc u_next_pc (
        .i_instr_pc     (r_instr_pc),
        .i_branch_taken (i_branch_taken),
        .i_branch_offset(i_branch_offset),
        .i_jump         (i_jump),
        .i_jump_index   (i_jump_index),
        .o_next_pc      (w_next_pc)
    );

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            FETCH_IDLE: w_state_next = FETCH;
            FETCH:      if (i_imem_ready) w_state_next = HOLD;
            HOLD:       if (i_instr_ack) w_state_next = FETCH;
            default:    w_state_next = FETCH_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= FETCH_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_pc          <= RESET_PC_ALIGNED;
            r_instr       <= INSTR_NOP;
            r_instr_pc    <= RESET_PC_ALIGNED;
            r_instr_valid <= 1'b0;
            r_instr_count <= 32'd0;
        end else begin
            if (w_fetch_done) begin
                r_instr       <= i_imem_rdata;
                r_instr_pc    <= r_pc;
                r_instr_valid <= 1'b1;
            end
            if (w_retire) begin
                r_pc          <= w_next_pc;
                r_instr_count <= r_instr_count + 32'd1;
                r_instr_valid <= 1'b0;
            end
        end
    end

    // Request is decoded from state alone so ready/ack never reach an output.
    assign o_imem_req    = (r_state == FETCH);
    assign o_imem_addr   = r_pc;
    assign o_instr       = r_instr;
    assign o_instr_pc    = r_instr_pc;
    assign o_instr_valid = r_instr_valid;
    assign o_instr_count = r_instr_count;

endmodule
